handshake_xbar_nxm: RTL and testbench

HANDSHAKE_XBAR_NXM -- requirements
Module: handshake_xbar_nxm

---
 rtl/handshake_xbar_nxm.sv | 136 +++++++++++++
 tb/tb_handshake_xbar_nxm.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_xbar_nxm.sv
// handshake_xbar_nxm: NUM_M x NUM_S valid/ready crossbar.
// Each beat is routed by its upper nibble (nibble - SLV_BASE selects the slave).
// Every slave owns a one-deep output register and a round-robin pointer that
// rotates past the master it last accepted from.
// Optional feature macro: XBAR_DECERR_EN. When defined, unmapped beats are
// swallowed at once and flagged on m_decerr the following cycle. When it is
// undefined, unmapped beats go to slave 0 and m_decerr is tied low.
module handshake_xbar_nxm #(
  parameter int NUM_M    = 2,
  parameter int NUM_S    = 2,
  parameter int DATA_W   = 8,
  parameter int SLV_BASE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M*DATA_W-1:0]  m_data,
  input  logic [NUM_M-1:0]         m_valid,
  output logic [NUM_M-1:0]         m_ready,
  output logic [NUM_S*DATA_W-1:0]  s_data,
  output logic [NUM_S-1:0]         s_valid,
  input  logic [NUM_S-1:0]         s_ready,
  output logic [NUM_M-1:0]         m_decerr
);

  localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SEL_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

`ifdef XBAR_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  logic [3:0]       nib     [NUM_M];
  logic [NUM_M-1:0] hit;
  logic [SEL_W-1:0] tgt     [NUM_M];
  logic [NUM_M-1:0] req     [NUM_S];
  logic [PTR_W-1:0] ptr     [NUM_S];
  logic [PTR_W-1:0] ptr_nxt [NUM_S];
  logic [PTR_W-1:0] gnt_idx [NUM_S];
  logic [NUM_S-1:0] free;
  logic [NUM_S-1:0] gnt_any;
  logic [NUM_M-1:0] ready_raw;

  // Decode each master's destination slave from the beat's upper nibble.
  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      nib[i] = m_data[i*DATA_W + DATA_W - 4 +: 4];
      hit[i] = (int'(nib[i]) >= SLV_BASE) && (int'(nib[i]) < SLV_BASE + NUM_S);
      // Unmapped beats fall back to slave 0; with the error feature they never
      // raise a slave request at all (see req below).
      tgt[i] = hit[i] ? SEL_W'(int'(nib[i]) - SLV_BASE) : '0;
    end
  end

  // Build the per-slave request vectors: req[j][i] means master i wants slave j.
  always_comb begin
    for (int j = 0; j < NUM_S; j++) begin
      for (int i = 0; i < NUM_M; i++) begin
        req[j][i] = m_valid[i] && (tgt[i] == SEL_W'(j)) && (hit[i] || !DECERR_EN);
      end
    end
  end

  // Round-robin arbitration per slave: first requester from ptr[j] upward wins,
  // but only when the slave register can take a beat this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned and infers a latch.
    for (int j = 0; j < NUM_S; j++) begin
      free[j]    = !s_valid[j] || s_ready[j];
      gnt_any[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int k = 0; k < NUM_M; k++) begin
        if (free[j] && !gnt_any[j] && req[j][(int'(ptr[j]) + k) % NUM_M]) begin
          gnt_any[j] = 1'b1;
          gnt_idx[j] = PTR_W'((int'(ptr[j]) + k) % NUM_M);
        end
      end
      ptr_nxt[j] = PTR_W'((int'(gnt_idx[j]) + 1) % NUM_M);
    end
  end

  // Return the grants to the masters; reset masks every ready.
  always_comb begin
    ready_raw = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (gnt_any[j]) begin
        ready_raw[gnt_idx[j]] = 1'b1;
      end
    end
    if (DECERR_EN) begin
      // Unmapped beats are consumed immediately without touching any slave.
      ready_raw = ready_raw | (m_valid & ~hit);
    end
    m_ready = ready_raw & {NUM_M{rst}};
  end

  // Slave output registers and round-robin pointers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      s_valid <= '0;
      s_data  <= '0;
      for (int j = 0; j < NUM_S; j++) begin
        ptr[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_S; j++) begin
        if (gnt_any[j]) begin
          // Load and drain may coincide, sustaining one beat per cycle.
          s_valid[j]                  <= 1'b1;
          s_data[j*DATA_W +: DATA_W]  <= m_data[int'(gnt_idx[j])*DATA_W +: DATA_W];
          ptr[j]                      <= ptr_nxt[j];
        end else if (s_ready[j]) begin
          s_valid[j] <= 1'b0;
        end
      end
    end
  end

`ifdef XBAR_DECERR_EN
  // One-cycle error pulse for every unmapped beat swallowed last cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_decerr <= '0;
    end else begin
      m_decerr <= m_valid & ~hit;
    end
  end
`else
  assign m_decerr = '0;
`endif

endmodule

// File: tb/tb_handshake_xbar_nxm.sv
// Testbench for handshake_xbar_nxm (default parameters: 2 masters, 2 slaves,
// 8-bit beats, slave 0 at nibble 2). Expected beats are queued per slave when
// the bench drives a beat it expects to be accepted; a negedge monitor pops and
// compares them whenever a slave transfer happens.
module tb_handshake_xbar_nxm;

  localparam int NUM_M    = 2;
  localparam int NUM_S    = 2;
  localparam int DATA_W   = 8;
  localparam int SLV_BASE = 2;

  logic                    clk;
  logic                    rst;
  logic [NUM_M*DATA_W-1:0] m_data;
  logic [NUM_M-1:0]        m_valid;
  logic [NUM_M-1:0]        m_ready;
  logic [NUM_S*DATA_W-1:0] s_data;
  logic [NUM_S-1:0]        s_valid;
  logic [NUM_S-1:0]        s_ready;
  logic [NUM_M-1:0]        m_decerr;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  handshake_xbar_nxm #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .DATA_W(DATA_W), .SLV_BASE(SLV_BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_decerr(m_decerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode: slave index, or -1 when the beat is swallowed as an error.
  function automatic int model_slave(input logic [DATA_W-1:0] beat);
    int d;
    d = int'(beat[DATA_W-1 -: 4]) - SLV_BASE;
    if (d >= 0 && d < NUM_S) return d;
`ifdef XBAR_DECERR_EN
    return -1;
`else
    return 0;
`endif
  endfunction

  // Scoreboard monitor: every slave transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int j = 0; j < NUM_S; j++) begin
        if (s_valid[j] === 1'b1 && s_ready[j] === 1'b1) begin
          logic [DATA_W-1:0] exp_beat;
          logic              have;
          have = 1'b0;
          exp_beat = '0;
          if (j == 0 && q0.size() > 0) begin exp_beat = q0.pop_front(); have = 1'b1; end
          if (j == 1 && q1.size() > 0) begin exp_beat = q1.pop_front(); have = 1'b1; end
          total++;
          if (!have) begin
            bad++;
            $display("FAIL sb_unexpected slave%0d: got=%h required=none", j, s_data[j*DATA_W +: DATA_W]);
          end else if (s_data[j*DATA_W +: DATA_W] !== exp_beat) begin
            bad++;
            $display("FAIL sb_data slave%0d: got=%h required=%h", j, s_data[j*DATA_W +: DATA_W], exp_beat);
          end
        end
      end
    end
  end

  // One cycle: drive inputs after the edge, check m_ready before the next edge,
  // queue the beats the bench expects to be accepted.
  task automatic step(input logic [NUM_M-1:0] v, input logic [NUM_M*DATA_W-1:0] d,
                      input logic [NUM_S-1:0] sr, input logic [NUM_M-1:0] er,
                      input string nm);
    @(posedge clk);
    #1;
    m_valid = v;
    m_data  = d;
    s_ready = sr;
    @(negedge clk);
    total++;
    if (m_ready !== er) begin
      bad++;
      $display("FAIL %s m_ready: got=%b required=%b", nm, m_ready, er);
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (er[i]) begin
        int s;
        s = model_slave(d[i*DATA_W +: DATA_W]);
        if (s == 0) q0.push_back(d[i*DATA_W +: DATA_W]);
        if (s == 1) q1.push_back(d[i*DATA_W +: DATA_W]);
      end
    end
  endtask

  task automatic idle(input string nm);
    step('0, '0, '1, '0, nm);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_valid = 2'b11;
    m_data  = 16'h2225;
    s_ready = 2'b11;
    @(negedge clk);
    total++;
    if (m_ready !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready: got=%b required=00", m_ready);
    end
    @(posedge clk);
    #1;
    m_valid = '0;
    @(negedge clk);
    total++;
    if (s_valid !== 2'b00 || s_data !== 16'h0000 || m_decerr !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: got valid=%b data=%h decerr=%b required 00/0000/00",
               s_valid, s_data, m_decerr);
    end
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Two masters contend for slave 0; pointer rotates after each accept.
  task automatic test_contention();
    step(2'b11, 16'h2221, 2'b11, 2'b01, "cont_m0_first");
    step(2'b11, 16'h2223, 2'b11, 2'b10, "cont_m1_second");
    step(2'b01, 16'h0023, 2'b11, 2'b01, "cont_m0_third");
    idle("cont_drain");
  endtask

  task automatic test_single();
    step(2'b01, 16'h0025, 2'b11, 2'b01, "single_accept");
    idle("single_next");
    total++;
    if (s_valid[0] !== 1'b1 || s_data[7:0] !== 8'h25) begin
      bad++;
      $display("FAIL single_out: got valid=%b data=%h required 1/25", s_valid[0], s_data[7:0]);
    end
  endtask

  task automatic test_parallel();
    step(2'b11, 16'h3B2A, 2'b11, 2'b11, "par_accept");
    idle("par_next");
    total++;
    if (s_valid !== 2'b11 || s_data !== 16'h3B2A) begin
      bad++;
      $display("FAIL par_out: got valid=%b data=%h required 11/3b2a", s_valid, s_data);
    end
  endtask

  task automatic test_backpressure();
    step(2'b10, 16'h3100, 2'b11, 2'b10, "bp_load");
    for (int c = 0; c < 3; c++) begin
      step(2'b01, 16'h0032, 2'b01, 2'b00, "bp_stall");
      total++;
      if (s_valid[1] !== 1'b1 || s_data[15:8] !== 8'h31) begin
        bad++;
        $display("FAIL bp_hold cycle%0d: got valid=%b data=%h required 1/31", c, s_valid[1], s_data[15:8]);
      end
    end
    step(2'b01, 16'h0032, 2'b11, 2'b01, "bp_release");
    idle("bp_drain");
    idle("bp_empty");
    total++;
    if (s_valid !== 2'b00) begin
      bad++;
      $display("FAIL bp_clear: got valid=%b required=00", s_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b0;
      logic [7:0] b1;
      b0 = 8'h20 + 8'(k);
      b1 = 8'h38 + 8'(k);
      step(2'b11, {b1, b0}, 2'b11, 2'b11, "b2b_stream");
    end
    idle("b2b_drain");
  endtask

  task automatic test_unmapped();
    step(2'b10, 16'h5000, 2'b11, 2'b10, "unm_accept");
    idle("unm_next");
`ifdef XBAR_DECERR_EN
    total++;
    if (m_decerr !== 2'b10 || s_valid !== 2'b00) begin
      bad++;
      $display("FAIL unm_decerr: got decerr=%b valid=%b required 10/00", m_decerr, s_valid);
    end
    // Both boundary codes (just below and just above the map) are errors.
    step(2'b11, 16'h401F, 2'b11, 2'b11, "unm_bounds");
    idle("unm_bounds_next");
    total++;
    if (m_decerr !== 2'b11 || s_valid !== 2'b00) begin
      bad++;
      $display("FAIL unm_bounds_decerr: got decerr=%b valid=%b required 11/00", m_decerr, s_valid);
    end
    idle("unm_quiet");
    total++;
    if (m_decerr !== 2'b00) begin
      bad++;
      $display("FAIL unm_pulse_width: got decerr=%b required=00", m_decerr);
    end
`else
    total++;
    if (s_valid[0] !== 1'b1 || s_data[7:0] !== 8'h50 || m_decerr !== 2'b00) begin
      bad++;
      $display("FAIL unm_route: got valid=%b data=%h decerr=%b required 1/50/00",
               s_valid[0], s_data[7:0], m_decerr);
    end
    // Boundary codes route to slave 0 and contend; M1 was last, so M0 wins.
    step(2'b11, 16'h401F, 2'b11, 2'b01, "unm_bounds_m0");
    step(2'b10, 16'h4000, 2'b11, 2'b10, "unm_bounds_m1");
    idle("unm_bounds_drain");
    total++;
    if (m_decerr !== 2'b00) begin
      bad++;
      $display("FAIL unm_decerr_tied: got decerr=%b required=00", m_decerr);
    end
`endif
  endtask

  task automatic test_reset_mid();
    // Park a beat in slave 0 (M0 accepted, so ptr[0] now favours M1).
    step(2'b01, 16'h0026, 2'b00, 2'b01, "rmid_load");
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_valid = 2'b11;
    m_data  = 16'h2828;
    s_ready = 2'b00;
    @(negedge clk);
    total++;
    if (m_ready !== 2'b00 || s_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL rmid_before_edge: got ready=%b valid0=%b required 00/1", m_ready, s_valid[0]);
    end
    @(posedge clk);
    #1;
    m_valid = '0;
    @(negedge clk);
    total++;
    if (s_valid !== 2'b00 || s_data !== 16'h0000) begin
      bad++;
      $display("FAIL rmid_cleared: got valid=%b data=%h required 00/0000", s_valid, s_data);
    end
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    s_ready = 2'b11;
    step(2'b11, 16'h2827, 2'b11, 2'b01, "rmid_first_contest");
    step(2'b10, 16'h2800, 2'b11, 2'b10, "rmid_second");
    idle("rmid_drain");
  endtask

  initial begin
    rst     = 1'b0;
    m_valid = '0;
    m_data  = '0;
    s_ready = '0;
    test_reset();
    test_contention();
    test_single();
    test_parallel();
    test_backpressure();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    idle("final_drain");
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got q0=%0d q1=%0d required 0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
